// File: rtl/sico_arb_pkg.sv
// Shared types and constants for the SiCo player-stream arbiter.
package sico_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  localparam int BEATS_W = 32;

endpackage

// File: rtl/sico_rr_pick.sv
// Combinational cyclic priority picker: grants the first request at or after ptr, wrapping to 0.
module sico_rr_pick #(
  parameter int NUM_SRC = 4,
  parameter int SRC_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [SRC_W-1:0]   ptr,
  output logic [NUM_SRC-1:0] gnt,
  output logic [SRC_W-1:0]   idx,
  output logic               any
);

  // Walk from the farthest slot back to ptr so the nearest request is written last.
  always_comb begin
    int pos_s;
    pos_s = 0;
    idx   = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      pos_s = (int'(ptr) + k >= NUM_SRC) ? int'(ptr) + k - NUM_SRC : int'(ptr) + k;
      idx   = req[pos_s] ? SRC_W'(pos_s) : idx;
    end
    any = |req;
    gnt = any ? (NUM_SRC'(1) << idx) : '0;
  end

endmodule

// File: rtl/sico_player_arbiter.sv
// Round-robin arbiter merging NUM_SRC SiCo player streams onto one registered output,
// tagged with the winning source index; a winner may keep the grant for up to MAX_BURST beats.
module sico_player_arbiter
  import sico_arb_pkg::*;
#(
  parameter int WIDTH     = 1,
  parameter int NUM_SRC   = 4,
  parameter int MAX_BURST = 1,
  parameter int SRC_W     = $clog2(NUM_SRC)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_SRC*WIDTH-1:0] src_data_i,
  input  logic [NUM_SRC-1:0]       src_valid_i,
  output logic [NUM_SRC-1:0]       src_hold_o,
  input  logic [NUM_SRC-1:0]       src_en_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [SRC_W-1:0]         src_o,
  output logic                     valid_o,
  input  logic                     hold_i,
  output logic [BEATS_W-1:0]       beats_o
);

  localparam int               CNT_W    = (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BURST);
  localparam logic [SRC_W-1:0] SRC_LAST = SRC_W'(NUM_SRC - 1);

  arb_state_e         state_r, next_state_s;
  logic [NUM_SRC-1:0] req_s, pick_gnt_s, win_oh_s;
  logic [SRC_W-1:0]   pick_idx_s, win_idx_s;
  logic [SRC_W-1:0]   ptr_r, ptr_next_s, owner_r, owner_next_s;
  logic [CNT_W-1:0]   cnt_r, cnt_next_s;
  logic               pick_any_s, free_s, load_s;
  logic               valid_r;
  logic [WIDTH-1:0]   data_r;
  logic [SRC_W-1:0]   src_r;
  logic [BEATS_W-1:0] beats_r;

  assign req_s  = src_valid_i & src_en_i;
  assign free_s = !valid_r || !hold_i;

  sico_rr_pick #(
    .NUM_SRC(NUM_SRC),
    .SRC_W  (SRC_W)
  ) u_pick (
    .req(req_s),
    .ptr(ptr_r),
    .gnt(pick_gnt_s),
    .idx(pick_idx_s),
    .any(pick_any_s)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // The pointer advances past every fresh winner, so a burst end or release already finds it at owner+1.
  always_comb begin
    next_state_s = state_r;
    load_s       = 1'b0;
    win_idx_s    = pick_idx_s;
    win_oh_s     = '0;
    cnt_next_s   = cnt_r;
    owner_next_s = owner_r;
    ptr_next_s   = ptr_r;
    case (state_r)
      IDLE: begin
        if (free_s && pick_any_s) begin
          load_s       = 1'b1;
          win_oh_s     = pick_gnt_s;
          cnt_next_s   = CNT_W'(1);
          owner_next_s = pick_idx_s;
          ptr_next_s   = (pick_idx_s == SRC_LAST) ? '0 : pick_idx_s + SRC_W'(1);
          next_state_s = (MAX_BURST > 1) ? LOCK : IDLE;
        end else begin
          next_state_s = IDLE;
        end
      end
      LOCK: begin
        if (!free_s) begin
          next_state_s = LOCK;
        end else if (req_s[owner_r]) begin
          load_s       = 1'b1;
          win_idx_s    = owner_r;
          win_oh_s     = NUM_SRC'(1) << owner_r;
          cnt_next_s   = cnt_r + CNT_W'(1);
          next_state_s = (cnt_next_s == CNT_MAX) ? IDLE : LOCK;
        end else if (pick_any_s) begin
          load_s       = 1'b1;
          win_oh_s     = pick_gnt_s;
          cnt_next_s   = CNT_W'(1);
          owner_next_s = pick_idx_s;
          ptr_next_s   = (pick_idx_s == SRC_LAST) ? '0 : pick_idx_s + SRC_W'(1);
          next_state_s = LOCK;
        end else begin
          next_state_s = IDLE;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  always_comb begin
    if (rst_i) begin
      src_hold_o = '1;
    end else if (load_s) begin
      src_hold_o = ~win_oh_s;
    end else begin
      src_hold_o = '1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_r   <= '0;
      cnt_r   <= '0;
      owner_r <= '0;
      valid_r <= 1'b0;
      data_r  <= '0;
      src_r   <= '0;
      beats_r <= '0;
    end else begin
      ptr_r   <= ptr_next_s;
      cnt_r   <= cnt_next_s;
      owner_r <= owner_next_s;
      if (load_s) begin
        valid_r <= 1'b1;
        data_r  <= src_data_i[int'(win_idx_s)*WIDTH +: WIDTH];
        src_r   <= win_idx_s;
      end else if (!hold_i) begin
        valid_r <= 1'b0;
      end
      if (valid_r && !hold_i) begin
        beats_r <= beats_r + BEATS_W'(1);
      end
    end
  end

  assign valid_o = valid_r;
  assign data_o  = data_r;
  assign src_o   = src_r;
  assign beats_o = beats_r;

endmodule
